// File: rtl/result_bcd_converter.sv
// Signed binary to packed BCD converter for the calculator display.
// Iterative double-dabble, one magnitude bit per clock, start/done handshake.
module result_bcd_converter #(
    parameter int IN_W = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IN_W-1:0] value,
    output logic            busy,
    output logic            done,
    output logic [9:0]      bcd,
    output logic            negative,
    output logic            overflow
);

    // Enough digits for any IN_W-bit magnitude, so a thousands carry
    // can never fall off the top and fake an in-range result.
    localparam int ND = (IN_W + 2) / 3;
    localparam int SW = 4 * ND;
    localparam int CW = $clog2(IN_W + 1);

    localparam logic [SW-1:0] LIMIT = SW'(12'h399);
    localparam logic [CW-1:0] LAST  = CW'(IN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SW-1:0]   r_scratch;
    logic [IN_W-1:0] r_mag;
    logic [CW-1:0]   r_cnt;
    logic            r_sign;
    logic            r_busy;
    logic            r_done;
    logic [9:0]      r_bcd;
    logic            r_neg;
    logic            r_ovf;

    logic [SW-1:0]   w_scratch_nxt;
    logic [IN_W-1:0] w_mag_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_sign_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic [9:0]      w_bcd_nxt;
    logic            w_neg_nxt;
    logic            w_ovf_nxt;

    logic [SW-1:0]   w_adj;
    logic [IN_W-1:0] w_abs;
    logic            w_ovf_det;

    // Magnitude of the incoming value; the most negative input maps to
    // 2^(IN_W-1) since the result is read as unsigned.
    always_comb begin
        w_abs = value[IN_W-1] ? (~value + 1'b1) : value;
    end

    // Add-3 correction on every digit that would exceed 9 after shifting.
    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < ND; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    // Range check on the finished BCD digits.
    always_comb begin
        w_ovf_det = (r_scratch > LIMIT);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_scratch_nxt = r_scratch;
        w_mag_nxt     = r_mag;
        w_cnt_nxt     = r_cnt;
        w_sign_nxt    = r_sign;
        w_done_nxt    = 1'b0;
        w_bcd_nxt     = r_bcd;
        w_neg_nxt     = r_neg;
        w_ovf_nxt     = r_ovf;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_sign_nxt    = value[IN_W-1];
                    w_mag_nxt     = w_abs;
                    w_scratch_nxt = '0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_scratch_nxt = {w_adj[SW-2:0], r_mag[IN_W-1]};
                w_mag_nxt     = {r_mag[IN_W-2:0], 1'b0};
                w_cnt_nxt     = r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_ovf_nxt   = w_ovf_det;
                w_bcd_nxt   = w_ovf_det ? 10'h000 : r_scratch[9:0];
                w_neg_nxt   = r_sign;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // Datapath and registered outputs; reset aborts any conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scratch <= '0;
            r_mag     <= '0;
            r_cnt     <= '0;
            r_sign    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= 10'h000;
            r_neg     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_scratch <= w_scratch_nxt;
            r_mag     <= w_mag_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sign    <= w_sign_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_bcd     <= w_bcd_nxt;
            r_neg     <= w_neg_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign negative = r_neg;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Scoreboard bench for result_bcd_converter (IN_W = 11).
// Stimulus pushes expected results; a monitor pops them on done.
module tb_result_bcd_converter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] value;
    logic        busy;
    logic        done;
    logic [9:0]  bcd;
    logic        negative;
    logic        overflow;

    typedef struct {
        logic [9:0] bcd;
        logic       neg;
        logic       ovf;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   checks;
    int   errors;

    result_bcd_converter #(.IN_W(11)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .negative (negative),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", n, a, e, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got bcd=%0h want=no_done cyc=%0d",
                         bcd, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("bcd", 32'(bcd), 32'(e.bcd));
                chk("negative", 32'(negative), 32'(e.neg));
                chk("overflow", 32'(overflow), 32'(e.ovf));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic convert(input logic [10:0] v, input logic [9:0] eb,
                           input logic en, input logic eo);
        @(negedge clk);
        start = 1'b1;
        value = v;
        sb.push_back('{eb, en, eo, cyc + 13});
        @(negedge clk);
        start = 1'b0;
        chk("busy_first", 32'(busy), 32'd1);
        repeat (11) @(negedge clk);
        chk("busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_clear", 32'(busy), 32'd0);
    endtask

    initial begin
        int c;
        int k;
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        value  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_neg", 32'(negative), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        convert(11'd255, 10'h255, 1'b0, 1'b0);
        convert(-11'sd123, 10'h123, 1'b1, 1'b0);
        convert(11'd399, 10'h399, 1'b0, 1'b0);
        convert(11'd400, 10'h000, 1'b0, 1'b1);
        convert(11'h400, 10'h000, 1'b1, 1'b1);
        convert(11'd0, 10'h000, 1'b0, 1'b0);
        convert(11'd1, 10'h001, 1'b0, 1'b0);
        convert(-11'sd400, 10'h000, 1'b1, 1'b1);
        convert(11'd1023, 10'h000, 1'b0, 1'b1);

        // Extra start pulses while converting must be ignored.
        @(negedge clk);
        start = 1'b1;
        value = 11'd7;
        sb.push_back('{10'h007, 1'b0, 1'b0, cyc + 13});
        @(negedge clk);
        start = 1'b0;
        k = cyc;
        repeat (3) @(negedge clk);
        start = 1'b1;
        value = 11'd9;
        @(negedge clk);
        start = 1'b0;
        while (cyc < k + 11) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("ignore_idle", 32'(busy), 32'd0);
        chk("ignore_drained", 32'(sb.size()), 32'd0);

        // Start held high: back-to-back conversions every 13 cycles.
        @(negedge clk);
        c = cyc;
        start = 1'b1;
        value = 11'd42;
        sb.push_back('{10'h042, 1'b0, 1'b0, c + 13});
        sb.push_back('{10'h042, 1'b0, 1'b0, c + 26});
        sb.push_back('{10'h042, 1'b0, 1'b0, c + 39});
        repeat (27) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("held_drained", 32'(sb.size()), 32'd0);

        // Reset in the middle of a conversion of 300.
        @(negedge clk);
        start = 1'b1;
        value = 11'd300;
        sb.push_back('{10'h300, 1'b0, 1'b0, cyc + 13});
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bcd", 32'(bcd), 32'd0);
        chk("abort_neg", 32'(negative), 32'd0);
        chk("abort_ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_quiet_bcd", 32'(bcd), 32'd0);

        convert(11'd300, 10'h300, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("final_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
